// File: rtl/sobel_feldman.sv
// sobel_feldman
//   Streaming 3x3 Sobel-Feldman edge-magnitude operator for luma pixels.
//   Upstream line buffers present one vertical 3-pixel column per clock.
//   The block keeps a 3-column window (L oldest, C, R newest) and computes
//   Gx/Gy (stage 1) and the saturated magnitude |Gx|+|Gy| (stage 2).
//   There is no handshake. A column sampled at edge N completes the window
//   at edge N, and the result for that window appears after edge N+2.
//
// Ports
//   i_pclk         pixel clock, rising edge
//   i_arst         asynchronous reset, active high
//   i_pixel_11_11  incoming column, top row (row offset -1)
//   i_pixel_00_11  incoming column, middle row (row offset 0)
//   i_pixel_01_11  incoming column, bottom row (row offset +1)
//   o_pixel        registered edge magnitude, saturated to Y_DEPTH bits

module sobel_feldman #(
  parameter int Y_DEPTH = 8
) (
  input  logic               i_pclk,
  input  logic               i_arst,
  input  logic [Y_DEPTH-1:0] i_pixel_11_11,
  input  logic [Y_DEPTH-1:0] i_pixel_00_11,
  input  logic [Y_DEPTH-1:0] i_pixel_01_11,
  output logic [Y_DEPTH-1:0] o_pixel
);

  // Gradient width: +/-4*(2^Y_DEPTH-1) needs Y_DEPTH+3 signed bits.
  localparam int GW = Y_DEPTH + 3;
  // Magnitude width: sum of two magnitudes up to 4*(2^Y_DEPTH-1) each.
  localparam int SW = Y_DEPTH + 4;

  typedef struct packed {
    logic [Y_DEPTH-1:0] top;
    logic [Y_DEPTH-1:0] mid;
    logic [Y_DEPTH-1:0] bot;
  } col_t;

  logic r_pclk;
  logic r_arst;

  assign r_pclk = i_pclk;
  assign r_arst = i_arst;

  col_t col_l;
  col_t col_c;
  col_t col_r;

  logic signed [GW-1:0] gx_q;
  logic signed [GW-1:0] gy_q;

  logic [GW-1:0]        sum_r_x;
  logic [GW-1:0]        sum_l_x;
  logic [GW-1:0]        sum_bot_y;
  logic [GW-1:0]        sum_top_y;
  logic signed [GW-1:0] gx_d;
  logic signed [GW-1:0] gy_d;

  logic [GW-1:0]        gx_abs;
  logic [GW-1:0]        gy_abs;
  logic [SW-1:0]        mag;
  logic [Y_DEPTH-1:0]   mag_sat;

  // Column window shift register
  always_ff @(posedge r_pclk or posedge r_arst) begin
    if (r_arst) begin
      col_l <= '0;
      col_c <= '0;
      col_r <= '0;
    end else begin
      col_l     <= col_c;
      col_c     <= col_r;
      col_r.top <= i_pixel_11_11;
      col_r.mid <= i_pixel_00_11;
      col_r.bot <= i_pixel_01_11;
    end
  end

  // Weighted sums are formed unsigned in GW bits (max 4*(2^Y_DEPTH-1) fits
  // in Y_DEPTH+2 bits), so the GW-bit difference is an exact signed result.
  always_comb begin
    sum_r_x   = {3'b000, col_r.top} + {2'b00, col_r.mid, 1'b0} + {3'b000, col_r.bot};
    sum_l_x   = {3'b000, col_l.top} + {2'b00, col_l.mid, 1'b0} + {3'b000, col_l.bot};
    sum_bot_y = {3'b000, col_l.bot} + {2'b00, col_c.bot, 1'b0} + {3'b000, col_r.bot};
    sum_top_y = {3'b000, col_l.top} + {2'b00, col_c.top, 1'b0} + {3'b000, col_r.top};
    gx_d      = $signed(sum_r_x - sum_l_x);
    gy_d      = $signed(sum_bot_y - sum_top_y);
  end

  // Stage 1: gradients
  always_ff @(posedge r_pclk or posedge r_arst) begin
    if (r_arst) begin
      gx_q <= '0;
      gy_q <= '0;
    end else begin
      gx_q <= gx_d;
      gy_q <= gy_d;
    end
  end

  // Negation cannot overflow: the most negative gradient is far from -2^(GW-1).
  always_comb begin
    gx_abs = gx_q[GW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
    gy_abs = gy_q[GW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
    mag    = {1'b0, gx_abs} + {1'b0, gy_abs};
    if (|mag[SW-1:Y_DEPTH]) begin
      mag_sat = '1;
    end else begin
      mag_sat = mag[Y_DEPTH-1:0];
    end
  end

  // Stage 2: saturated magnitude
  always_ff @(posedge r_pclk or posedge r_arst) begin
    if (r_arst) begin
      o_pixel <= '0;
    end else begin
      o_pixel <= mag_sat;
    end
  end

endmodule

// File: tb/tb_sobel_feldman.sv
// tb_sobel_feldman
//   Directed bench for sobel_feldman. Columns are driven on the falling edge;
//   o_pixel is sampled 1 ns after each rising edge. The output seen after
//   edge k belongs to the window completed at edge k-2.

module tb_sobel_feldman;

  logic       i_pclk = 1'b0;
  logic       i_arst;
  logic [7:0] t_in;
  logic [7:0] m_in;
  logic [7:0] b_in;
  logic [7:0] o_pixel;

  int total = 0;
  int bad   = 0;

  sobel_feldman #(.Y_DEPTH(8)) dut (
    .i_pclk        (i_pclk),
    .i_arst        (i_arst),
    .i_pixel_11_11 (t_in),
    .i_pixel_00_11 (m_in),
    .i_pixel_01_11 (b_in),
    .o_pixel       (o_pixel)
  );

  always #5 i_pclk = ~i_pclk;

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int t, input int m, input int b);
    @(negedge i_pclk);
    t_in = t[7:0];
    m_in = m[7:0];
    b_in = b[7:0];
    @(posedge i_pclk);
    #1;
  endtask

  task automatic step_chk(input string tag, input int t, input int m, input int b,
                          input int exp);
    step(t, m, b);
    check_val(tag, int'(o_pixel), exp);
  endtask

  task automatic do_reset();
    @(negedge i_pclk);
    t_in   = 8'd0;
    m_in   = 8'd0;
    b_in   = 8'd0;
    i_arst = 1'b1;
    @(negedge i_pclk);
    @(negedge i_pclk);
    i_arst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with nonzero inputs
    i_arst = 1'b1;
    t_in   = 8'd200;
    m_in   = 8'd50;
    b_in   = 8'd7;
    #1;
    check_val("rst_async", int'(o_pixel), 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge i_pclk);
      #1;
      check_val("rst_hold", int'(o_pixel), 0);
    end
    @(negedge i_pclk);
    t_in   = 8'd0;
    m_in   = 8'd0;
    b_in   = 8'd0;
    i_arst = 1'b0;
    step_chk("rst_rel0", 0, 0, 0, 0);
    step_chk("rst_rel1", 0, 0, 0, 0);
    check_val("rst_gx", int'(dut.gx_q), 0);
    check_val("rst_gy", int'(dut.gy_q), 0);

    // Flat field: first windows see zero history on the left
    do_reset();
    step_chk("flat1", 100, 100, 100, 0);
    step_chk("flat2", 100, 100, 100, 0);
    step_chk("flat3", 100, 100, 100, 255);
    step_chk("flat4", 100, 100, 100, 255);
    step_chk("flat5", 100, 100, 100, 0);
    step_chk("flat6", 100, 100, 100, 0);
    check_val("flat_gx", int'(dut.gx_q), 0);
    check_val("flat_gy", int'(dut.gy_q), 0);

    // Vertical edge: Gx=40 two clocks after the third column
    do_reset();
    step_chk("vert1", 0, 0, 0, 0);
    step_chk("vert2", 0, 0, 0, 0);
    step_chk("vert3", 10, 10, 10, 0);
    step_chk("vert4", 0, 0, 0, 0);
    step_chk("vert5", 0, 0, 0, 40);
    step_chk("vert6", 0, 0, 0, 0);

    // Horizontal edge: steady column (0,0,50) gives Gy=200
    do_reset();
    step_chk("horz1", 0, 0, 50, 0);
    step_chk("horz2", 0, 0, 50, 0);
    step_chk("horz3", 0, 0, 50, 100);
    step_chk("horz4", 0, 0, 50, 200);
    step_chk("horz5", 0, 0, 50, 200);
    step_chk("horz6", 0, 0, 50, 200);

    // Small values, signed gradients, partial windows on both sides
    do_reset();
    step_chk("small1", 1, 2, 3, 0);
    step_chk("small2", 4, 5, 6, 0);
    step_chk("small3", 7, 8, 9, 10);
    step_chk("small4", 0, 0, 0, 26);
    step_chk("small5", 0, 0, 0, 32);
    step_chk("small6", 0, 0, 0, 26);
    step_chk("small7", 0, 0, 0, 34);
    step_chk("small8", 0, 0, 0, 0);

    // Saturation: window (225,0,76),(105,255,149),(178,128,29) -> S=372
    do_reset();
    step_chk("sat1", 225, 0, 76, 0);
    step_chk("sat2", 105, 255, 149, 0);
    step_chk("sat3", 178, 128, 29, 255);
    step_chk("sat4", 0, 0, 0, 255);
    check_val("sat_gx", int'(dut.gx_q), 162);
    check_val("sat_gy", int'(dut.gy_q), -210);
    step_chk("sat5", 0, 0, 0, 255);
    step_chk("sat6", 0, 0, 0, 255);
    step_chk("sat7", 0, 0, 0, 255);
    step_chk("sat8", 0, 0, 0, 0);

    // Saturation threshold: S=254 passes through, S=256 clips
    do_reset();
    step_chk("bnd1", 0, 0, 127, 0);
    step_chk("bnd2", 0, 0, 1, 0);
    step_chk("bnd_254", 0, 0, 0, 254);
    step_chk("bnd_256a", 0, 0, 0, 255);
    step_chk("bnd_256b", 0, 0, 0, 255);
    step_chk("bnd6", 0, 0, 0, 2);
    step_chk("bnd7", 0, 0, 0, 0);

    // Reset mid-stream: output clears at once, history is lost
    do_reset();
    step_chk("mid1", 0, 0, 200, 0);
    step_chk("mid2", 0, 0, 200, 0);
    step_chk("mid3", 0, 0, 200, 255);
    step_chk("mid4", 0, 0, 200, 255);
    #2;
    i_arst = 1'b1;
    #1;
    check_val("mid_rst_out", int'(o_pixel), 0);
    check_val("mid_rst_gx", int'(dut.gx_q), 0);
    check_val("mid_rst_gy", int'(dut.gy_q), 0);
    @(negedge i_pclk);
    t_in = 8'd0;
    m_in = 8'd0;
    b_in = 8'd0;
    @(posedge i_pclk);
    #1;
    check_val("mid_rst_hold", int'(o_pixel), 0);
    @(negedge i_pclk);
    i_arst = 1'b0;
    step_chk("refill1", 10, 10, 10, 0);
    step_chk("refill2", 0, 0, 0, 0);
    step_chk("refill3", 0, 0, 0, 40);
    step_chk("refill4", 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
